// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared FSM state type and ALU opcode constants
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_MAX = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SGE = 5'b00101;
    localparam logic [4:0] OP_NOP = 5'b01111;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: one requester's operation request and result response channels
interface alu_arbiter_if #(
    parameter int W   = 24,
    parameter int OPW = 5
);
    logic           valid;
    logic           ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPW-1:0] op;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   result;
    logic           zero;

    modport master (
        output valid, a, b, op, resp_ready,
        input  ready, resp_valid, result, zero
    );

    modport slave (
        input  valid, a, b, op, resp_ready,
        output ready, resp_valid, result, zero
    );
endinterface

// File: rtl/alu_rr_picker.sv
// alu_rr_picker: two-way one-hot grant, round-robin on contention or port 0 fixed priority
module alu_rr_picker (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       rr_en,
    output logic [1:0] grant
);
    assign grant[0] = valid[0] & (~valid[1] | ~rr_en | ~ptr);
    assign grant[1] = valid[1] & (~valid[0] | (rr_en & ptr));
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with an accept/issue/respond FSM
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W       = 24,
    parameter int OPW     = 5,
    parameter int ALU_LAT = 1,
    parameter int RR_EN   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_arbiter_if.slave   p0,
    alu_arbiter_if.slave   p1,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_zero,
    output logic           busy
);
    localparam int CW = $clog2(ALU_LAT + 1);

    state_t        state, next_state;
    logic          owner, ptr;
    logic [CW-1:0] cnt;
    logic [W-1:0]  result_q;
    logic          zero_q;
    logic [1:0]    valid, grant;
    logic          own_ready, other_valid, accept, capture, done;

    assign valid       = {p1.valid, p0.valid};
    assign own_ready   = owner ? p1.resp_ready : p0.resp_ready;
    assign other_valid = owner ? p0.valid : p1.valid;

    alu_rr_picker u_pick (
        .valid (valid),
        .ptr   (ptr),
        .rr_en (RR_EN != 0),
        .grant (grant)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // next state plus the accept/capture/response-done strobes
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                accept     = |valid;
                next_state = accept ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: begin
                capture    = (cnt == '0);
                next_state = capture ? S_RESP : S_ISSUE;
            end
            S_RESP: begin
                done       = own_ready;
                next_state = own_ready ? S_IDLE : S_RESP;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // operand latch, latency count, result capture and fairness pointer;
    // the pointer only moves when the other port was left waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= 1'b0;
            ptr      <= 1'b0;
            cnt      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            if (accept) begin
                owner  <= grant[1];
                alu_a  <= grant[1] ? p1.a : p0.a;
                alu_b  <= grant[1] ? p1.b : p0.b;
                alu_op <= grant[1] ? p1.op : p0.op;
                cnt    <= CW'(ALU_LAT - 1);
            end
            if (state == S_ISSUE && !capture) cnt <= cnt - 1'b1;
            if (capture) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
            end
            if (done && RR_EN != 0 && other_valid) ptr <= ~owner;
        end
    end

    // ready is masked by reset so every output reads 0 while rst_n is low
    assign p0.ready      = rst_n & accept & grant[0];
    assign p1.ready      = rst_n & accept & grant[1];
    assign p0.resp_valid = (state == S_RESP) & ~owner;
    assign p1.resp_valid = (state == S_RESP) & owner;
    assign p0.result     = result_q;
    assign p1.result     = result_q;
    assign p0.zero       = zero_q;
    assign p1.zero       = zero_q;
    assign busy          = (state != S_IDLE);
endmodule
